stark_regfile_lvt_nwnr: RTL
===========================

# stark_regfile_lvt_nwnr

Parametrised multi-port physical register file for the Stark core: WPORTS write ports, RPORTS read ports, built from one 1W/RPORTS-R RAM bank per write port, selected by a live value table (LVT). It adds four things: registered, valid-qualified reads with write-to-read forwarding; separate value and tag write enables; a same-cycle write-collision detector; and a post-reset clear sequencer. It sits between the writeback/commit buses and the issue/operand-read stage.

## Interface
- WID, 64, value width in bits (tag is 1 extra bit)
- DEP, PREGS, number of physical registers; power of two, >= 4
- WPORTS, 4, number of write ports, 1..8
- RPORTS, 16, number of read ports, 1..32
- AW, $clog2(DEP), address width (derived)
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  WPORTS  per-port write strobe
- we  in  2*WPORTS  per-port enables: bit 0 = write value, bit 1 = write tag
- wa  in  AW*WPORTS  per-port write address
- i  in  WID*WPORTS  per-port write value
- ti  in  WPORTS  per-port write tag
- rv  in  RPORTS  per-port read request valid
- ra  in  AW*RPORTS  per-port read address
- ov  out  RPORTS  read data valid, one cycle after request
- o  out  WID*RPORTS  read value
- to  out  RPORTS  read tag
- busy  out  1  clear sequence in progress; writes and reads are refused
- coll  out  1  one-cycle pulse: two or more ports wrote the same field of the same register

## Operation
- Storage: bank k is written only by port k. Two LVTs of DEP x ceil(log2 WPORTS) bits each: one for the value and one for the tag. A value write on port k sets lvt_v[wa]=k; a tag write sets lvt_t[wa]=k.
- Effective write: wr[k] && !busy && wa[k]!=0. A value write is an effective write with we[k][0]=1; a tag write is an effective write with we[k][1]=1. A value-only write leaves the tag untouched, and a tag-only write leaves the value untouched.
- Register 0: always reads value 0 and tag 0. Writes to it are dropped and do not count toward coll.
- Same-cycle write conflict on the same field and address: the highest-numbered port wins, in both the RAM result and the LVT. coll pulses the following cycle.
- Read semantics: a request accepted in cycle N returns, in cycle N+1, the register contents after all of cycle N's writes are applied (write-then-read). Value and tag are resolved independently through their own LVT, with forwarding applied per field.
- When rv[g]=0: ov[g]=0, and o[g]/to[g] hold their previous values.
- Clear FSM, states CLEAR and RUN:
  - rst forces CLEAR, sets the counter to 0, and sets all LVT entries to 0.
  - In CLEAR, each cycle writes value 0 and tag 0 to bank 0 at the counter address, then increments the counter.
  - After address DEP-1 is written, the FSM moves to RUN.
  - rst asserted in any state restarts CLEAR from address 0.

## Timing
- Reset values, held while rst=1: busy=1, ov=0, o=0, to=0, coll=0.
- busy stays high for exactly DEP cycles after rst deasserts, then falls. The first accepted read or write is in the cycle busy is 0.
- While busy: wr, we and rv are ignored, ov=0, coll=0.
- Read latency is 1 cycle (ov/o/to registered), with full throughput: a new request every cycle per port.
- A write in cycle N is visible to a read requested in cycle N (through forwarding) and in every later cycle.
- coll is asserted in cycle N+1 for a conflict in cycle N, one cycle wide per conflicting cycle.

## Test plan
- Reset then clear, DEP=16: hold rst for 3 cycles, release, then request reads of all 16 registers.
  - Required: busy high for 16 cycles after release.
  - Required: reads issued while busy give ov=0.
  - Required: after busy falls, every read gives o=0, to=0, ov=1.
- Write/read forwarding: port 2 writes r5=0x1234, tag 1, in cycle N; read port 7 requests r5 in cycle N.
  - Required: in cycle N+1, o[7]=0x1234, to[7]=1, ov[7]=1.
  - Required: the same values are returned by a read of r5 in cycle N+5.
- Split fields across ports: port 0 writes r9 value 0xAA with we=01; the next cycle port 3 writes r9 tag 1 with we=10.
  - Required: a read of r9 returns o=0xAA, to=1.
- Collision: ports 1 and 3 write r12 values 0x11 and 0x33 in the same cycle.
  - Required: coll=1 for exactly one cycle.
  - Required: a later read of r12 returns 0x33.
- Register zero: port 0 writes r0=0xFFFF, and port 1 writes r0 in the same cycle.
  - Required: coll stays 0.
  - Required: a read of r0 returns o=0, to=0.
- Reset mid-operation: write r3=0x77, then assert rst for 1 cycle partway through traffic.
  - Required: busy is high again for DEP cycles.
  - Required: after busy falls, r3 reads 0.

Source files
------------

// File: rtl/stark_regfile_lvt_nwnr.sv
// stark_regfile_lvt_nwnr: multi-port physical register file for the Stark core.
// Each write port owns one 1W/RPORTS-R bank. Two live value tables, one for
// the value field and one for the tag field, record which bank holds the
// latest copy of each register. Reads are registered and valid-qualified, and
// a write made in the same cycle as a read is forwarded to it. After reset, a
// clear sequencer zeroes bank 0 while all LVT entries point at bank 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr, we, wa, i,  per write port: strobe, {tag_en, value_en}, address,
//   ti              value, tag
//   rv, ra          per read port: request valid, address
//   ov, o, to       per read port: registered valid, value, tag
//   busy            clear sequence running; reads and writes are refused
//   coll            one-cycle pulse after a same-field, same-address write clash
module stark_regfile_lvt_nwnr #(
  parameter int unsigned WID    = 64,
  parameter int unsigned DEP    = 64,
  parameter int unsigned WPORTS = 4,
  parameter int unsigned RPORTS = 16,
  localparam int unsigned AW    = $clog2(DEP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WPORTS-1:0]      wr,
  input  logic [2*WPORTS-1:0]    we,
  input  logic [AW*WPORTS-1:0]   wa,
  input  logic [WID*WPORTS-1:0]  i,
  input  logic [WPORTS-1:0]      ti,
  input  logic [RPORTS-1:0]      rv,
  input  logic [AW*RPORTS-1:0]   ra,
  output logic [RPORTS-1:0]      ov,
  output logic [WID*RPORTS-1:0]  o,
  output logic [RPORTS-1:0]      to,
  output logic                   busy,
  output logic                   coll
);

  localparam int unsigned LW = (WPORTS > 1) ? $clog2(WPORTS) : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          clr_we_c;

  // Clear sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear sequencer next state: one bank-0 address zeroed per cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we_c  = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we_c = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == AW'(DEP - 1)) state_nxt = S_RUN;
      end
      default: ;
    endcase
  end

  assign busy = (state == S_CLEAR);

  logic [AW-1:0]  wa_a [WPORTS];
  logic [WID-1:0] wi_a [WPORTS];
  logic [WPORTS-1:0] wv_c, wt_c;
  logic           coll_c;

  // Effective per-field write strobes; register 0 writes are dropped here
  always_comb begin
    wv_c = '0;
    wt_c = '0;
    for (int k = 0; k < WPORTS; k++) begin
      wa_a[k] = wa[k*AW +: AW];
      wi_a[k] = i[k*WID +: WID];
      wv_c[k] = wr[k] && !busy && (wa_a[k] != '0) && we[2*k];
      wt_c[k] = wr[k] && !busy && (wa_a[k] != '0) && we[2*k+1];
    end
  end

  // Two ports hitting the same field of the same register in one cycle
  always_comb begin
    coll_c = 1'b0;
    for (int j = 0; j < WPORTS; j++) begin
      for (int k = j + 1; k < WPORTS; k++) begin
        if (wa_a[j] == wa_a[k] &&
            ((wv_c[j] && wv_c[k]) || (wt_c[j] && wt_c[k])))
          coll_c = 1'b1;
      end
    end
  end

  logic [WID-1:0] mem_v [WPORTS][DEP];
  logic           mem_t [WPORTS][DEP];

  // Banks: port k writes only bank k; the clear sequencer borrows bank 0
  always_ff @(posedge clk) begin
    for (int k = 0; k < WPORTS; k++) begin
      if (wv_c[k]) mem_v[k][wa_a[k]] <= wi_a[k];
      if (wt_c[k]) mem_t[k][wa_a[k]] <= ti[k];
    end
    if (clr_we_c) begin
      mem_v[0][cnt] <= '0;
      mem_t[0][cnt] <= 1'b0;
    end
  end

  logic [LW-1:0] lvt_v [DEP];
  logic [LW-1:0] lvt_t [DEP];

  // LVTs: ascending loop lets the highest-numbered port win a clash
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEP; a++) begin
        lvt_v[a] <= '0;
        lvt_t[a] <= '0;
      end
    end else begin
      for (int k = 0; k < WPORTS; k++) begin
        if (wv_c[k]) lvt_v[wa_a[k]] <= LW'(k);
        if (wt_c[k]) lvt_t[wa_a[k]] <= LW'(k);
      end
    end
  end

  logic [AW-1:0]     ra_a     [RPORTS];
  logic [WID-1:0]    rd_v_c   [RPORTS];
  logic [RPORTS-1:0] rd_t_c;

  // Read resolve: LVT-selected bank, overridden per field by this cycle's writes
  always_comb begin
    rd_t_c = '0;
    for (int g = 0; g < RPORTS; g++) begin
      ra_a[g]   = ra[g*AW +: AW];
      rd_v_c[g] = mem_v[lvt_v[ra_a[g]]][ra_a[g]];
      rd_t_c[g] = mem_t[lvt_t[ra_a[g]]][ra_a[g]];
      for (int k = 0; k < WPORTS; k++) begin
        if (wv_c[k] && wa_a[k] == ra_a[g]) rd_v_c[g] = wi_a[k];
        if (wt_c[k] && wa_a[k] == ra_a[g]) rd_t_c[g] = ti[k];
      end
      if (ra_a[g] == '0) begin
        rd_v_c[g] = '0;
        rd_t_c[g] = 1'b0;
      end
    end
  end

  // Registered read outputs; data holds when no request is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      ov   <= '0;
      o    <= '0;
      to   <= '0;
      coll <= 1'b0;
    end else begin
      coll <= coll_c;
      for (int g = 0; g < RPORTS; g++) begin
        ov[g] <= rv[g] && !busy;
        if (rv[g] && !busy) begin
          o[g*WID +: WID] <= rd_v_c[g];
          to[g]           <= rd_t_c[g];
        end
      end
    end
  end

endmodule
